// File: rtl/ctrl_pkg.sv
// Shared encodings and the control bundle for the ID/EX control stage.
package ctrl_pkg;

  // Primary opcodes (instr[31:26]) the decoder accepts.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0]) the decoder accepts.
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU operation encodings carried in the control bundle.
  localparam int unsigned ALU_W = 4;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_MUL  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b1101;
  localparam logic [ALU_W-1:0] ALU_NONE = 4'b1111;

  // Branch kind encodings.
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  // Control half of the ID/EX register.
  typedef struct packed {
    logic             mem_to_reg;
    logic             reg_write;
    logic             mem_write;
    logic             mem_read;
    logic             alu_src;
    logic             reg_dst;
    logic             jump;
    logic [1:0]       branch;
    logic [ALU_W-1:0] alu_ctrl;
  } ctrl_t;

  // A bubble performs no architectural action.
  localparam ctrl_t CTRL_BUBBLE = '{
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    mem_write:  1'b0,
    mem_read:   1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    jump:       1'b0,
    branch:     BR_NONE,
    alu_ctrl:   ALU_NONE
  };

  // Multiply sequencer view: BUSY whenever the cycle counter is non-zero.
  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // rt is read as a source operand only by these opcodes; for the
  // I-type ALU ops and lw it is a destination.
  function automatic logic rt_is_source(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational decode of the ID-stage instruction into the
// control bundle, register indices and an unsupported-encoding flag.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_id,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        rt_src,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_shamt;

  assign op    = instr_id[31:26];
  assign funct = instr_id[5:0];
  assign rs    = instr_id[25:21];
  assign rt    = instr_id[20:16];
  assign rd    = instr_id[15:11];

  // The shift amount field plays no part in any supported encoding.
  assign unused_shamt = ^instr_id[10:6];

  // Operand-role lookup used by the load-use check.
  assign rt_src = rt_is_source(op);

  // Opcode/funct to control bundle; unknown encodings collapse to a bubble.
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b0;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_ctrl = ALU_SUB;
          FN_AND:          ctrl.alu_ctrl = ALU_AND;
          FN_OR:           ctrl.alu_ctrl = ALU_OR;
          FN_NOR:          ctrl.alu_ctrl = ALU_NOR;
          FN_XOR:          ctrl.alu_ctrl = ALU_XOR;
          FN_SLT:          ctrl.alu_ctrl = ALU_SLT;
          FN_MUL:          ctrl.alu_ctrl = ALU_MUL;
          default:         illegal       = 1'b1;
        endcase
      end
      OP_BEQ: begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.branch   = BR_BEQ;
      end
      OP_BNE: begin
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.branch   = BR_BNE;
      end
      OP_LW: begin
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (op)
          OP_ANDI: ctrl.alu_ctrl = ALU_AND;
          OP_ORI:  ctrl.alu_ctrl = ALU_OR;
          OP_XORI: ctrl.alu_ctrl = ALU_XOR;
          default: ctrl.alu_ctrl = ALU_ADD;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl = CTRL_BUBBLE;
    end
  end

endmodule

// File: rtl/id_ex_control.sv
// ID/EX control register with load-use bubble insertion, multi-cycle mul
// sequencing and branch flush.
//
// Flow control: stall=1 means "ID is not accepted this cycle" -- upstream
// must hold PC and IF/ID. ex_hold=1 means "EX content is not complete" --
// downstream must not advance EX. An instruction in ID is consumed on the
// rising edge where stall=0 and flush=0.
module id_ex_control
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int MULT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_id,
  input  logic                  instr_valid,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_hold,
  output logic                  ex_valid,
  output logic                  ex_illegal,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_write,
  output logic                  ex_mem_read,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic                  ex_jump,
  output logic [1:0]            ex_branch,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_rd
);

  localparam int MCNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MULT_CYCLES - 1);
  localparam logic [MCNT_W-1:0] MCNT_ONE  = MCNT_W'(1);

  // Decoder outputs
  ctrl_t      dec_ctrl;
  logic       dec_illegal;
  logic       dec_rt_src;
  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic [4:0] dec_rd;

  // ID/EX register state
  ctrl_t             ctrl_q,    ctrl_d;
  logic [4:0]        rs_q,      rs_d;
  logic [4:0]        rt_q,      rt_d;
  logic [4:0]        rd_q,      rd_d;
  logic              valid_q,   valid_d;
  logic              illegal_q, illegal_d;
  logic              hold_q,    hold_d;
  logic [MCNT_W-1:0] mcnt_q,    mcnt_d;

  // Hazard and sequencer observation
  mul_state_e mul_state;
  logic       load_use;

  instr_decoder u_dec (
    .instr_id (instr_id),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .rt_src   (dec_rt_src),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .rd       (dec_rd)
  );

  // Sequencer state derived from the remaining-cycle counter.
  always_comb begin
    mul_state = (mcnt_q != '0) ? MUL_BUSY : MUL_IDLE;
  end

  // Load-use: the load in EX writes a register that ID wants to read.
  always_comb begin
    load_use = 1'b0;
    if (valid_q && ctrl_q.mem_read && (rt_q != 5'd0)) begin
      load_use = (rt_q == dec_rs) || (dec_rt_src && (rt_q == dec_rt));
    end
  end

  assign stall = (mul_state == MUL_BUSY) || load_use;

  // Next ID/EX contents: flush, then mul freeze, then load-use bubble,
  // then idle bubble, then illegal bubble, then the decoded instruction.
  always_comb begin
    ctrl_d    = ctrl_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    mcnt_d    = mcnt_q;
    if (flush) begin
      ctrl_d    = CTRL_BUBBLE;
      rs_d      = 5'd0;
      rt_d      = 5'd0;
      rd_d      = 5'd0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      mcnt_d    = '0;
    end else if (mul_state == MUL_BUSY) begin
      mcnt_d = mcnt_q - MCNT_ONE;
    end else if (load_use || !instr_valid || dec_illegal) begin
      ctrl_d    = CTRL_BUBBLE;
      rs_d      = 5'd0;
      rt_d      = 5'd0;
      rd_d      = 5'd0;
      valid_d   = 1'b0;
      illegal_d = instr_valid && !load_use && dec_illegal;
    end else begin
      ctrl_d    = dec_ctrl;
      rs_d      = dec_rs;
      rt_d      = dec_rt;
      rd_d      = dec_rd;
      valid_d   = 1'b1;
      illegal_d = 1'b0;
      if (dec_ctrl.alu_ctrl == ALU_MUL) begin
        mcnt_d = MCNT_LOAD;
      end
    end
    hold_d = (mcnt_d != '0);
  end

  // Pipeline register and multiply counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_BUBBLE;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      hold_q    <= 1'b0;
      mcnt_q    <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      hold_q    <= hold_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign ex_hold       = hold_q;
  assign ex_valid      = valid_q;
  assign ex_illegal    = illegal_q;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_jump       = ctrl_q.jump;
  assign ex_branch     = ctrl_q.branch;
  assign ex_alu_ctrl   = ALU_CTRL_W'(ctrl_q.alu_ctrl);
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;

endmodule

// File: tb/tb_id_ex_control.sv
// Bench for id_ex_control: directed test-plan sequences followed by a
// random instruction stream, checked against a reference model.
module tb_id_ex_control;

  localparam int MC = 4;
  localparam int W  = 31;
  localparam logic [W-1:0] RESET_VEC = {3'b000, 7'b0000000, 2'b00, 4'b1111, 15'd0};

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_id;
  logic        instr_valid;
  logic        flush;
  logic        stall, ex_hold, ex_valid, ex_illegal;
  logic        ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_mem_read;
  logic        ex_alu_src, ex_reg_dst, ex_jump;
  logic [1:0]  ex_branch;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  always #5 clk = ~clk;

  id_ex_control #(.ALU_CTRL_W(4), .MULT_CYCLES(MC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_id      (instr_id),
    .instr_valid   (instr_valid),
    .flush         (flush),
    .stall         (stall),
    .ex_hold       (ex_hold),
    .ex_valid      (ex_valid),
    .ex_illegal    (ex_illegal),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_read   (ex_mem_read),
    .ex_alu_src    (ex_alu_src),
    .ex_reg_dst    (ex_reg_dst),
    .ex_jump       (ex_jump),
    .ex_branch     (ex_branch),
    .ex_alu_ctrl   (ex_alu_ctrl),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd)
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {ex_valid, ex_illegal, ex_hold, ex_mem_to_reg, ex_reg_write,
                    ex_mem_write, ex_mem_read, ex_alu_src, ex_reg_dst, ex_jump,
                    ex_branch, ex_alu_ctrl, ex_rs, ex_rt, ex_rd};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic         stall_exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_valid, m_illegal, m_mtr, m_rw, m_mw, m_mr, m_as, m_rdst;
  logic [1:0] m_br;
  logic [3:0] m_alu;
  logic [4:0] m_rs, m_rt, m_rd;
  int         m_busy;   // frozen cycles still to come for a mul in EX

  function automatic logic [W-1:0] model_vec();
    return {m_valid, m_illegal, (m_busy > 0), m_mtr, m_rw, m_mw, m_mr, m_as,
            m_rdst, 1'b0, m_br, m_alu, m_rs, m_rt, m_rd};
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_illegal = 0; m_mtr = 0; m_rw = 0; m_mw = 0; m_mr = 0;
    m_as = 0; m_rdst = 0; m_br = 2'b00; m_alu = 4'b1111;
    m_rs = 0; m_rt = 0; m_rd = 0;
  endtask

  task automatic model_reset();
    model_bubble();
    m_busy = 0;
  endtask

  function automatic logic model_load_use(input logic [31:0] ins);
    logic [5:0] op;
    logic       rt_read;
    op      = ins[31:26];
    rt_read = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    return m_valid && m_mr && (m_rt != 5'd0) &&
           ((m_rt == ins[25:21]) || (rt_read && (m_rt == ins[20:16])));
  endfunction

  task automatic model_decode(input logic [31:0] ins);
    logic [5:0] op, fn;
    logic       bad;
    op = ins[31:26];
    fn = ins[5:0];
    bad = 0;
    model_bubble();
    case (op)
      6'h00: begin
        m_rw = 1;
        case (fn)
          6'h20, 6'h21: m_alu = 4'b0010;
          6'h22, 6'h23: m_alu = 4'b0110;
          6'h24:        m_alu = 4'b0000;
          6'h25:        m_alu = 4'b0001;
          6'h26:        m_alu = 4'b1101;
          6'h27:        m_alu = 4'b1100;
          6'h2A:        m_alu = 4'b0111;
          6'h18:        m_alu = 4'b1000;
          default:      bad = 1;
        endcase
      end
      6'h04: begin m_alu = 4'b0110; m_br = 2'b01; end
      6'h05: begin m_alu = 4'b0110; m_br = 2'b10; end
      6'h23: begin m_alu = 4'b0010; m_as = 1; m_rdst = 1; m_mr = 1; m_mtr = 1; m_rw = 1; end
      6'h2B: begin m_alu = 4'b0010; m_as = 1; m_mw = 1; end
      6'h08, 6'h09: begin m_alu = 4'b0010; m_as = 1; m_rdst = 1; m_rw = 1; end
      6'h0C: begin m_alu = 4'b0000; m_as = 1; m_rdst = 1; m_rw = 1; end
      6'h0D: begin m_alu = 4'b0001; m_as = 1; m_rdst = 1; m_rw = 1; end
      6'h0E: begin m_alu = 4'b1101; m_as = 1; m_rdst = 1; m_rw = 1; end
      default: bad = 1;
    endcase
    if (bad) begin
      model_bubble();
      m_illegal = 1;
    end else begin
      m_valid = 1;
      m_rs = ins[25:21];
      m_rt = ins[20:16];
      m_rd = ins[15:11];
      if (op == 6'h00 && fn == 6'h18) m_busy = MC - 1;
    end
  endtask

  // ---------------- driver ----------------
  // Presents one ID cycle and pushes the expected stall and ID/EX contents.
  task automatic step(input logic [31:0] ins, input logic v, input logic f);
    logic lu;
    @(negedge clk);
    instr_id    = ins;
    instr_valid = v;
    flush       = f;
    lu = model_load_use(ins);
    stall_exp_q.push_back((m_busy > 0) || lu);
    if (f) begin
      model_bubble();
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (lu || !v) begin
      model_bubble();
    end else begin
      model_decode(ins);
    end
    exp_q.push_back(model_vec());
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  r_fn [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h18};
    logic [5:0]  i_op [5]  = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E};
    logic [5:0]  bad_op [4] = '{6'h02, 6'h03, 6'h0F, 6'h3F};
    logic [5:0]  bad_fn [3] = '{6'h00, 6'h08, 6'h19};
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2, 3: return {6'h00, rs, rt, rd, 5'd0, r_fn[$urandom_range(0, 9)]};
      4, 11:      return {6'h23, rs, rt, imm};
      5:          return {6'h2B, rs, rt, imm};
      6:          return {($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, rs, rt, imm};
      7:          return {i_op[$urandom_range(0, 4)], rs, rt, imm};
      8:          return {6'h00, rs, rt, rd, 5'd0, 6'h18};
      9:          return {bad_op[$urandom_range(0, 3)], rs, rt, imm};
      default:    return {6'h00, rs, rt, rd, 5'd0, bad_fn[$urandom_range(0, 2)]};
    endcase
  endfunction

  // ---------------- monitors ----------------
  // Registered outputs after each edge against the queued expectation.
  always @(posedge clk) begin : mon_regs
    logic [W-1:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("id_ex_regs", dut_vec, e);
    end
  end

  // Combinational stall mid-cycle, once inputs have settled.
  always @(negedge clk) begin : mon_stall
    logic e;
    #2;
    if (rst_n && stall_exp_q.size() > 0) begin
      e = stall_exp_q.pop_front();
      check("stall", stall, e);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; instr_id = 32'd0; instr_valid = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_regs", dut_vec, RESET_VEC);
    check("reset_stall", stall, 0);
    @(negedge clk);
    rst_n = 1;

    // add $3,$1,$2
    step(32'h00221820, 1, 0);
    @(posedge clk); #2;
    check("add_reg_write", ex_reg_write, 1);
    check("add_alu", ex_alu_ctrl, 4'b0010);
    check("add_rd", ex_rd, 5'd3);

    // lw $2 then add reading $2: one bubble, then the add
    step(32'h8C220000, 1, 0);
    step(32'h00452020, 1, 0);
    @(posedge clk); #2;
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_alu", ex_alu_ctrl, 4'b1111);
    step(32'h00452020, 1, 0);
    @(posedge clk); #2;
    check("lu_add_rd", ex_rd, 5'd4);

    // lw $0 then add using $0: no stall
    step(32'h8C200000, 1, 0);
    step(32'h00001820, 1, 0);

    // sw
    step(32'hAC220004, 1, 0);
    @(posedge clk); #2;
    check("sw_mem_write", ex_mem_write, 1);
    check("sw_mem_read", ex_mem_read, 0);
    check("sw_reg_write", ex_reg_write, 0);

    // mul: frozen for MC-1 cycles, then the add enters
    step(32'h00223018, 1, 0);
    @(posedge clk); #2;
    check("mul_alu", ex_alu_ctrl, 4'b1000);
    check("mul_hold", ex_hold, 1);
    for (int i = 0; i < MC - 1; i++) step(32'h00221820, 1, 0);
    @(posedge clk); #2;
    check("mul_last_alu", ex_alu_ctrl, 4'b1000);
    check("mul_hold_drop", ex_hold, 0);
    step(32'h00221820, 1, 0);

    // mul aborted by flush in the second busy cycle
    step(32'h00223018, 1, 0);
    step(32'h00221820, 1, 0);
    step(32'h00221820, 1, 1);
    @(posedge clk); #2;
    check("flush_hold", ex_hold, 0);
    check("flush_valid", ex_valid, 0);
    step(32'h00221820, 1, 0);

    // unknown opcode
    step(32'hFC000000, 1, 0);
    @(posedge clk); #2;
    check("ill_flag", ex_illegal, 1);
    check("ill_reg_write", ex_reg_write, 0);
    check("ill_alu", ex_alu_ctrl, 4'b1111);

    // idle slot
    step(32'h00221820, 0, 0);

    // load-use against a mul in ID: bubble first, then mul issues
    step(32'h8C220000, 1, 0);
    step(32'h00423018, 1, 0);
    step(32'h00423018, 1, 0);
    for (int i = 0; i < MC - 1; i++) step(32'h00000000, 0, 0);

    // asynchronous reset in the middle of a mul
    step(32'h00223018, 1, 0);
    step(32'h00221820, 1, 0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("async_rst_regs", dut_vec, RESET_VEC);
    check("async_rst_stall", stall, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // random stream
    for (int i = 0; i < 600; i++) begin
      step(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0));
    end

    @(posedge clk); #3;
    check("exp_q_drained", exp_q.size(), 0);
    check("stall_q_drained", stall_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_control.md
# id_ex_control

Registered decode and control stage for the five-stage MIPS core, sitting between the IF/ID register and EX. It decodes the ID-stage instruction into control bits and holds them in the control half of the ID/EX pipeline register. It detects load-use hazards and inserts bubbles, and sequences a multi-cycle `mul` through EX. It also handles flush from branch resolution and flags unsupported encodings.

## Interface
Parameters:
- `ALU_CTRL_W`, 4, width of the ALU control field.
- `MULT_CYCLES`, 4, number of cycles `mul` occupies EX; must be ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr_id`  in  32  instruction currently in ID.
- `instr_valid`  in  1  `instr_id` is a real instruction; when 0 it is treated as a bubble.
- `flush`  in  1  branch taken or jump resolved in MEM; kills the ID/EX contents.
- `stall`  out  1  combinational; holds PC and IF/ID.
- `ex_hold`  out  1  registered; EX must not advance while a `mul` is in progress.
- `ex_valid`, `ex_illegal`  out  1 each  registered.
- `ex_mem_to_reg`, `ex_reg_write`, `ex_mem_write`, `ex_mem_read`, `ex_alu_src`, `ex_reg_dst`, `ex_jump`  out  1 each  registered control.
- `ex_branch`  out  2  00 none, 01 beq, 10 bne.
- `ex_alu_ctrl`  out  ALU_CTRL_W  ALU operation.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  registered register indices.

## Operation
- ALU encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, MUL 1000, NOR 1100, XOR 1101, NONE 1111.
- R-type instructions (op 0x00):
  - add/addu → ADD; sub/subu → SUB; and, or, nor, xor, slt map to their named operation.
  - `mul` (funct 0x18) → MUL.
  - All R-type: reg_write=1, reg_dst=0.
- beq (op 0x04) / bne (op 0x05): SUB, reg_write=0.
- lw (0x23): ADD, alu_src=1, reg_dst=1, mem_read=1, mem_to_reg=1.
- sw (0x2B): ADD, alu_src=1, mem_write=1, mem_read=0, reg_write=0.
- addi, addiu, andi, ori, xori (0x08, 0x09, 0x0C, 0x0D, 0x0E): ADD, ADD, AND, OR, XOR respectively; alu_src=1, reg_dst=1, reg_write=1.
- Any other opcode or funct produces a bubble with `ex_illegal=1`. A bubble has all control bits 0 and alu_ctrl NONE.
- Load-use hazard:
  - `stall=1` when all of: `ex_valid`, `ex_mem_read`, `ex_rt≠0`, and `ex_rt` equals the ID rs, or equals the ID rt where rt is a source.
  - rt is a source for R-type, beq, bne and sw only.
  - On a load-use stall, ID/EX loads a bubble.
- Multi-cycle `mul`, with counter `mcnt` and states IDLE (`mcnt=0`) and BUSY (`mcnt≠0`):
  - Issuing `mul` into ID/EX loads `mcnt=MULT_CYCLES-1`.
  - In BUSY: ID/EX is frozen, `stall=1`, `ex_hold=1`, and `mcnt` decrements every cycle.
  - With `MULT_CYCLES=1` the block never enters BUSY.
- Update priority at each edge: reset > flush (bubble, `mcnt←0`) > BUSY freeze > load-use bubble > load decoded instruction.
- `instr_valid=0` with no other event: load a bubble with `ex_illegal=0`.

## Timing
- Reset values:
  - Control bits and `ex_branch`: 0.
  - `ex_alu_ctrl`: 1111.
  - `ex_rs`, `ex_rt`, `ex_rd`: 0.
  - `ex_valid`, `ex_illegal`, `ex_hold`: 0.
  - `mcnt`: 0, so `stall` reads 0.
- Decode-to-`ex_*` latency: 1 cycle.
- `stall` is combinational from ID/EX state and `instr_id` in the same cycle.
- `mul` occupies EX for exactly `MULT_CYCLES` cycles; the next instruction enters ID/EX at the edge after BUSY ends.
- A load-use stall lasts exactly 1 cycle.
- Load-use hazard against a `mul` in ID: the bubble goes first, then `mul` issues.
- Flush during BUSY aborts the `mul`; `ex_hold` drops next cycle.
- Asserting `rst_n` low mid-BUSY returns outputs to reset values immediately.

## Structure
- Package `ctrl_pkg` holds:
  - opcode and funct localparams;
  - ALU and branch encodings;
  - a packed struct for the control bundle and a `CTRL_BUBBLE` constant.
- One sub-module, `instr_decoder`: purely combinational `instr_id` → control struct plus illegal flag.
- Hazard logic, `mcnt` and the pipeline register live in `id_ex_control`.

## Test plan
- Reset, then `instr_id=0x00221820` (add $3,$1,$2) → next cycle: `ex_reg_write=1`, `ex_alu_ctrl=0010`, `ex_rd=3`, `stall=0`.
- `0x8C220000` (lw $2,0($1)), then `0x00452020` (add $4,$2,$5) → `stall=1` for one cycle; ID/EX shows a bubble, then the add.
- `0x8C200000` (lw $0), then `0x00001820` (add using $0) → no stall.
- `0xAC220004` (sw) → `ex_mem_write=1`, `ex_mem_read=0`, `ex_reg_write=0`.
- With `MULT_CYCLES=4`, issue `0x00223018` (mul) → `stall=1` and `ex_hold=1` for 3 cycles while ID/EX holds `alu_ctrl=1000`. Repeat and assert `flush` in the 2nd BUSY cycle → bubble, `stall=0` next cycle.
- `0xFC000000` (unknown opcode) → `ex_illegal=1`, `ex_reg_write=0`, `ex_alu_ctrl=1111`.
